calc_mem: RTL and testbench
===========================

Name: calc_mem

Overview:
- Shared 256x32 operand/result memory between the PS load interface and the matrix calculator.
- Accepts PS writes of packed operands (addr 255) and instructions (addr 1..5), then raises `ready`.
- Services the calculator's cmd/address_pl/data_pl requests until `done_pl`.
- Lets the PS read results back from addresses 6..10.

Parameters:
- DEPTH, 256, number of 32-bit words; address width is fixed at 8.
- DATA_ADDR, 8'd255, address of the packed operand word.
- INSTR_FIRST, 8'd1, first instruction address; instructions occupy 1..5.
- RES_FIRST, 8'd6, first result address; results occupy 6..10.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ps_we  in  1  PS write strobe.
- ps_addr  in  8  PS write/read address.
- ps_wdata  in  32  PS write data.
- ps_re  in  1  PS read strobe.
- ps_rdata  out  32  PS read data, registered.
- ps_start  in  1  PS request to launch calculation.
- ps_clear  in  1  PS request to return from DONE to LOAD.
- ps_err  out  1  one-cycle pulse on a rejected PS request.
- ps_busy  out  1  high while in RUN.
- irq_done  out  1  one-cycle pulse on entering DONE.
- cmd  in  3  calculator command: 2=write, 3=read, all others idle.
- address_pl  in  8  calculator address.
- data_pl  in  32  calculator write data.
- done_pl  in  1  calculator finished (level).
- data_in  out  32  read data to calculator, registered.
- ready  out  1  operands loaded, calculator may start.
- wr_viol  out  1  sticky write-guard flag (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - State=LOAD; load_mask=6'b0.
  - data_in, ps_rdata = 0.
  - ready, ps_busy, ps_err, irq_done, wr_viol = 0.
  - Memory array is not reset.
- Memory: single array, synchronous write, registered read. Read latency is 1 cycle (data valid the cycle after the request). A read and a write to the same address in the same cycle return the old data.
- LOAD:
  - ps_we writes mem[ps_addr]<=ps_wdata.
  - Writing to address 255 or 1..5 sets the matching load_mask bit.
  - ps_re: ps_rdata<=mem[ps_addr] next cycle.
  - Calculator cmd is ignored; data_in holds.
  - ps_start with load_mask==6'h3F -> RUN; ready<=1 and ps_busy<=1 in the same edge.
  - ps_start with an incomplete mask -> ps_err pulses for 1 cycle; stay in LOAD.
  - ps_start and ps_we in the same cycle: the write is performed first and counted toward the mask.
- RUN:
  - cmd=3 -> data_in<=mem[address_pl].
  - cmd=2 -> mem[address_pl]<=data_pl.
  - Any other cmd -> data_in holds.
  - PS port is locked: ps_we/ps_re/ps_start each assert ps_err for 1 cycle with no memory effect.
  - done_pl=1 (sampled) -> DONE; ready<=0, ps_busy<=0, irq_done pulses 1 cycle.
  - A cmd=2 in the same cycle as done_pl is still performed.
- DONE:
  - ps_re is serviced as in LOAD.
  - ps_we and ps_start -> ps_err.
  - ps_clear -> LOAD with load_mask cleared; memory is kept.
  - Relaunch requires the calculator to be reset externally; this block does not drive calculator reset.
- ps_clear outside DONE is ignored, with no error.
- Reset asserted mid-RUN aborts immediately; memory contents may hold partial results.

Optional Feature:
- Macro CALC_MEM_WR_GUARD_EN.
- With it defined:
  - In RUN, a calculator write (cmd=2) outside RES_FIRST..RES_FIRST+4 is dropped.
  - wr_viol is set sticky, cleared only by rst or by ps_clear.
- Without it: all calculator writes are accepted and wr_viol is tied to 0.

Decomposition:
- Package calc_mem_pkg:
  - cmd encodings CMD_WRITE=3'd2, CMD_READ=3'd3, CMD_IDLE=3'd4.
  - State enum LOAD/RUN/DONE.
  - Address constants DATA_ADDR, INSTR_FIRST, RES_FIRST, RES_LAST.
- One sub-module, calc_mem_ram: 256x32 array, one write port, two registered read ports. The control FSM, mask and guard stay in calc_mem.

Test Plan:
- Load and launch: write 255<=32'h1234_5678, 1..5<=0,1,2,3,4, then ps_start -> ready=1 and ps_busy=1 the next cycle.
- Incomplete load: skip addr 3, then ps_start -> ps_err 1-cycle pulse, ready stays 0, state stays LOAD.
- Calculator traffic in RUN: cmd=3 at addr 255 -> data_in=32'h1234_5678 one cycle later. cmd=2 at addr 6 with data 32'hDEAD_BEEF, then a read of 6 -> 32'hDEAD_BEEF.
- PS lockout in RUN: ps_we at addr 7 with 32'h1 -> ps_err pulse; a later calculator read of 7 returns the prior value.
- Completion: done_pl=1 -> ready=0 and a single irq_done pulse. PS read of addr 6 -> 32'hDEAD_BEEF. ps_clear -> LOAD with mask cleared.
- With CALC_MEM_WR_GUARD_EN: calculator cmd=2 at addr 2 in RUN -> mem[2] unchanged and wr_viol=1 until ps_clear.

Source files
------------

// File: rtl/calc_mem_pkg.sv
// Shared constants, command encodings and state type for calc_mem.
package calc_mem_pkg;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 32;
    localparam int unsigned CMD_W  = 3;
    localparam int unsigned MASK_W = 6;
    localparam int unsigned N_INSTR = 5;

    localparam logic [CMD_W-1:0] CMD_WRITE = 3'd2;
    localparam logic [CMD_W-1:0] CMD_READ  = 3'd3;
    localparam logic [CMD_W-1:0] CMD_IDLE  = 3'd4;

    localparam logic [AW-1:0] DATA_ADDR   = 8'd255;
    localparam logic [AW-1:0] INSTR_FIRST = 8'd1;
    localparam logic [AW-1:0] RES_FIRST   = 8'd6;
    localparam logic [AW-1:0] RES_LAST    = 8'd10;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Load-mask bit for a PS write address: bit 0 = operand word, bits 1..5 = instructions.
    function automatic logic [MASK_W-1:0] load_bit(input logic [AW-1:0] addr);
        logic [MASK_W-1:0] res;
        res = '0;
        if (addr == DATA_ADDR) begin
            res = MASK_W'(1);
        end
        for (int unsigned k = 0; k < N_INSTR; k++) begin
            if (addr == (INSTR_FIRST + AW'(k))) begin
                res = res | (MASK_W'(2) << k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/calc_mem_ram.sv
// 256x32 storage: one synchronous write port, two registered read ports.
// A read colliding with a write to the same address returns the old word.
module calc_mem_ram
    import calc_mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_a_i,
    input  logic [AW-1:0] addr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic          re_b_i,
    input  logic [AW-1:0] addr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_a_q;
    logic [DW-1:0] rdata_b_q;

    // Array write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port A (PS side), holds when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a_q <= '0;
        end else if (re_a_i) begin
            rdata_a_q <= mem_q[addr_a_i];
        end
    end

    // Read port B (calculator side), holds when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_b_q <= '0;
        end else if (re_b_i) begin
            rdata_b_q <= mem_q[addr_b_i];
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/calc_mem.sv
// Operand/result memory shared between the PS load port and the matrix calculator.
// Optional: define CALC_MEM_WR_GUARD_EN to restrict calculator writes to the
// result window and flag violations on wr_viol.
module calc_mem
    import calc_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ps_we,
    input  logic [AW-1:0]    ps_addr,
    input  logic [DW-1:0]    ps_wdata,
    input  logic             ps_re,
    output logic [DW-1:0]    ps_rdata,
    input  logic             ps_start,
    input  logic             ps_clear,
    output logic             ps_err,
    output logic             ps_busy,
    output logic             irq_done,
    input  logic [CMD_W-1:0] cmd,
    input  logic [AW-1:0]    address_pl,
    input  logic [DW-1:0]    data_pl,
    input  logic             done_pl,
    output logic [DW-1:0]    data_in,
    output logic             ready,
    output logic             wr_viol
);

    state_e              state_q, state_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic                irq_q, irq_d;

    logic                ram_we;
    logic [AW-1:0]       ram_waddr;
    logic [DW-1:0]       ram_wdata;
    logic                ram_re_a;
    logic                ram_re_b;

`ifdef CALC_MEM_WR_GUARD_EN
    logic                viol_q, viol_d;
    logic                in_res_win;

    assign in_res_win = (address_pl >= RES_FIRST) && (address_pl <= RES_LAST);
`endif

    calc_mem_ram u_ram (
        .clk       (clk),
        .rst       (rst),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .re_a_i    (ram_re_a),
        .addr_a_i  (ps_addr),
        .rdata_a_o (ps_rdata),
        .re_b_i    (ram_re_b),
        .addr_b_i  (address_pl),
        .rdata_b_o (data_in)
    );

    // State and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
            mask_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
        end
    end

`ifdef CALC_MEM_WR_GUARD_EN
    // Sticky write-guard flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_q <= 1'b0;
        end else begin
            viol_q <= viol_d;
        end
    end
`endif

    // Next-state, memory port steering and pulse generation.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        err_d     = 1'b0;
        irq_d     = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = ps_addr;
        ram_wdata = ps_wdata;
        ram_re_a  = 1'b0;
        ram_re_b  = 1'b0;
`ifdef CALC_MEM_WR_GUARD_EN
        viol_d    = viol_q;
`endif

        case (state_q)
            ST_LOAD: begin
                ram_re_a = ps_re;
                // A write in the same cycle as ps_start counts toward the mask.
                if (ps_we) begin
                    ram_we = 1'b1;
                    mask_d = mask_q | load_bit(ps_addr);
                end
                if (ps_start) begin
                    if (&mask_d) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                err_d     = ps_we | ps_re | ps_start;
                ram_re_b  = (cmd == CMD_READ);
                ram_waddr = address_pl;
                ram_wdata = data_pl;
                if (cmd == CMD_WRITE) begin
`ifdef CALC_MEM_WR_GUARD_EN
                    if (in_res_win) begin
                        ram_we = 1'b1;
                    end else begin
                        viol_d = 1'b1;
                    end
`else
                    ram_we = 1'b1;
`endif
                end
                if (done_pl) begin
                    state_d = ST_DONE;
                    ready_d = 1'b0;
                    busy_d  = 1'b0;
                    irq_d   = 1'b1;
                end
            end

            ST_DONE: begin
                ram_re_a = ps_re;
                err_d    = ps_we | ps_start;
                if (ps_clear) begin
                    state_d = ST_LOAD;
                    mask_d  = '0;
`ifdef CALC_MEM_WR_GUARD_EN
                    viol_d  = 1'b0;
`endif
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign ready    = ready_q;
    assign ps_busy  = busy_q;
    assign ps_err   = err_q;
    assign irq_done = irq_q;
`ifdef CALC_MEM_WR_GUARD_EN
    assign wr_viol  = viol_q;
`else
    assign wr_viol  = 1'b0;
`endif

endmodule

// File: tb/tb_calc_mem.sv
// Randomized self-checking bench for calc_mem with a cycle-level behavioural model.
module tb_calc_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps_we, ps_re, ps_start, ps_clear;
    logic [7:0]  ps_addr;
    logic [31:0] ps_wdata;
    logic [31:0] ps_rdata;
    logic        ps_err, ps_busy, irq_done;
    logic [2:0]  cmd;
    logic [7:0]  address_pl;
    logic [31:0] data_pl;
    logic        done_pl;
    logic [31:0] data_in;
    logic        ready, wr_viol;

`ifdef CALC_MEM_WR_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    always #5 clk = ~clk;

    calc_mem dut (
        .clk(clk), .rst(rst),
        .ps_we(ps_we), .ps_addr(ps_addr), .ps_wdata(ps_wdata),
        .ps_re(ps_re), .ps_rdata(ps_rdata),
        .ps_start(ps_start), .ps_clear(ps_clear),
        .ps_err(ps_err), .ps_busy(ps_busy), .irq_done(irq_done),
        .cmd(cmd), .address_pl(address_pl), .data_pl(data_pl),
        .done_pl(done_pl), .data_in(data_in),
        .ready(ready), .wr_viol(wr_viol)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0=loading, 1=calculating, 2=finished.
    logic [31:0] m_mem [256];
    bit          m_written [256];
    int          m_phase;
    logic [31:0] m_data_in, m_rdata;
    bit          m_ready, m_busy, m_err, m_irq, m_viol;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit operands_loaded();
        bit ok;
        ok = m_written[255];
        for (int i = 1; i <= 5; i++) ok = ok && m_written[i];
        return ok;
    endfunction

    task automatic model_step();
        m_err = 1'b0;
        m_irq = 1'b0;
        if (m_phase == 0) begin
            if (ps_re) m_rdata = m_mem[ps_addr];
            if (ps_we) begin
                m_mem[ps_addr]     = ps_wdata;
                m_written[ps_addr] = 1'b1;
            end
            if (ps_start) begin
                if (operands_loaded()) begin
                    m_phase = 1; m_ready = 1'b1; m_busy = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_phase == 1) begin
            m_err = ps_we || ps_re || ps_start;
            if (cmd == 3'd3) m_data_in = m_mem[address_pl];
            if (cmd == 3'd2) begin
                if (GUARD && !(address_pl >= 8'd6 && address_pl <= 8'd10)) m_viol = 1'b1;
                else m_mem[address_pl] = data_pl;
            end
            if (done_pl) begin
                m_phase = 2; m_ready = 1'b0; m_busy = 1'b0; m_irq = 1'b1;
            end
        end else begin
            if (ps_re) m_rdata = m_mem[ps_addr];
            m_err = ps_we || ps_start;
            if (ps_clear) begin
                m_phase = 0;
                m_viol  = 1'b0;
                for (int i = 0; i < 256; i++) m_written[i] = 1'b0;
            end
        end
    endtask

    task automatic idle_inputs();
        ps_we = 1'b0; ps_re = 1'b0; ps_start = 1'b0; ps_clear = 1'b0;
        cmd = 3'd4; done_pl = 1'b0;
    endtask

    // Advance one clock with the currently driven inputs and compare every output.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check({tag, "/ready"},    32'(ready),    32'(m_ready));
        check({tag, "/ps_busy"},  32'(ps_busy),  32'(m_busy));
        check({tag, "/ps_err"},   32'(ps_err),   32'(m_err));
        check({tag, "/irq_done"}, 32'(irq_done), 32'(m_irq));
        check({tag, "/wr_viol"},  32'(wr_viol),  32'(m_viol));
        check({tag, "/data_in"},  data_in,       m_data_in);
        check({tag, "/ps_rdata"}, ps_rdata,      m_rdata);
        idle_inputs();
    endtask

    task automatic ps_write(input logic [7:0] a, input logic [31:0] d, input string tag);
        ps_we = 1'b1; ps_addr = a; ps_wdata = d;
        tick(tag);
    endtask

    task automatic calc(input logic [2:0] c, input logic [7:0] a, input logic [31:0] d, input string tag);
        cmd = c; address_pl = a; data_pl = d;
        tick(tag);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  a8;
        idle_inputs();
        ps_addr = '0; ps_wdata = '0; address_pl = '0; data_pl = '0;
        m_phase = 0; m_data_in = '0; m_rdata = '0;
        m_ready = 0; m_busy = 0; m_err = 0; m_irq = 0; m_viol = 0;
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = '0;
            m_written[i] = 1'b0;
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst/ready",    32'(ready),    32'd0);
        check("rst/ps_busy",  32'(ps_busy),  32'd0);
        check("rst/ps_err",   32'(ps_err),   32'd0);
        check("rst/irq_done", 32'(irq_done), 32'd0);
        check("rst/wr_viol",  32'(wr_viol),  32'd0);
        check("rst/data_in",  data_in,       32'd0);
        check("rst/ps_rdata", ps_rdata,      32'd0);
        rst = 1'b0;
        tick("post_rst");

        // Incomplete load: instruction 3 missing.
        ps_write(8'd255, 32'h1234_5678, "inc_wr");
        for (int i = 1; i <= 5; i++) begin
            if (i != 3) ps_write(8'(i), 32'(i - 1), "inc_wr");
        end
        ps_start = 1'b1;
        tick("inc_start");
        check("inc_start_err", 32'(ps_err), 32'd1);
        check("inc_start_ready", 32'(ready), 32'd0);
        ps_clear = 1'b1;
        tick("clear_in_load");

        for (int r = 0; r < 3; r++) begin
            if (r > 0) begin
                ps_start = 1'b1;
                tick("start_after_clear");
            end
            // Full load with ignored calculator noise and, after round 0, overlapping reads.
            for (int a = 0; a < 256; a++) begin
                if (a == 255) d = 32'h1234_5678;
                else if (a >= 1 && a <= 5) d = 32'(a - 1);
                else d = $urandom;
                cmd = 3'($urandom_range(0, 7));
                address_pl = 8'($urandom);
                data_pl = $urandom;
                if (r > 0) ps_re = 1'($urandom_range(0, 1));
                if (r == 1 && a == 255) ps_start = 1'b1;
                ps_write(8'(a), d, "load");
            end
            if (r != 1) begin
                ps_start = 1'b1;
                tick("start");
            end
            check("run_ready", 32'(ready), 32'd1);
            check("run_busy", 32'(ps_busy), 32'd1);

            calc(3'd3, 8'd255, 32'h0, "rd255");
            check("rd255_val", data_in, 32'h1234_5678);
            calc(3'd2, 8'd6, 32'hDEAD_BEEF, "wr6");
            calc(3'd3, 8'd6, 32'h0, "rd6");
            check("rd6_val", data_in, 32'hDEAD_BEEF);
            ps_addr = 8'd7; ps_wdata = 32'h1; ps_we = 1'b1;
            tick("lock_we");
            check("lock_we_err", 32'(ps_err), 32'd1);
            calc(3'd3, 8'd7, 32'h0, "rd7");
            ps_clear = 1'b1;
            tick("clear_in_run");
            calc(3'd2, 8'd2, 32'hBAD0_0002, "wr2");
            calc(3'd3, 8'd2, 32'h0, "rd2");
            calc(3'd5, 8'd255, 32'h0, "idle_hold");

            for (int k = 0; k < 150; k++) begin
                cmd = 3'($urandom_range(0, 7));
                a8 = 8'($urandom);
                if (cmd == 3'd2 && a8 == 8'd6) a8 = 8'd7;
                address_pl = a8;
                data_pl = $urandom;
                ps_addr = 8'($urandom);
                ps_we = ($urandom_range(0, 7) == 0);
                ps_re = ($urandom_range(0, 7) == 0);
                ps_start = ($urandom_range(0, 7) == 0);
                tick("run_rand");
            end

            cmd = 3'd2; address_pl = 8'd8; data_pl = $urandom; done_pl = 1'b1;
            tick("done");
            check("done_irq", 32'(irq_done), 32'd1);
            check("done_ready", 32'(ready), 32'd0);
            done_pl = 1'b1;
            tick("done_after");
            check("irq_single", 32'(irq_done), 32'd0);

            ps_re = 1'b1; ps_addr = 8'd6;
            tick("done_rd6");
            check("done_rd6_val", ps_rdata, 32'hDEAD_BEEF);
            ps_re = 1'b1; ps_addr = 8'd8;
            tick("done_rd8");
            ps_write(8'd9, 32'h5555_AAAA, "done_we");
            ps_start = 1'b1;
            tick("done_start");
            for (int k = 0; k < 20; k++) begin
                ps_re = 1'b1;
                ps_addr = 8'($urandom_range(0, 255));
                cmd = 3'($urandom_range(0, 7));
                address_pl = 8'($urandom);
                tick("done_rand_rd");
            end
            ps_clear = 1'b1;
            tick("clear");
            tick("load_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
